// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - FSM state encoding (IDLE, ACCESS, RESP)
//   - helper that classifies a funct3 as unsupported for a given direction
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Loads reject 011/110/111; stores accept only SB/SH/SW.
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        logic bad;
        if (write) begin
            bad = !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: purely combinational byte-lane logic.
// Ports:
//   funct3_i, write_i, addr_lo_i  - access type and address low bits
//   wdata_i  / we_o, wdata_o      - store path: lane enables, replicated data
//   rdata_i  / rdata_o            - load path: extracted and extended data
//   misaligned_o, illegal_o       - access classification (illegal wins)
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        write_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        illegal_o    = f3_illegal(write_i, funct3_i);
        misaligned_o = 1'b0;
        // funct3[1:0] encodes size for both directions: 01=half, 10=word.
        case (funct3_i[1:0])
            2'b01:   misaligned_o = addr_lo_i[0];
            2'b10:   misaligned_o = (addr_lo_i != 2'b00);
            default: misaligned_o = 1'b0;
        endcase
        if (illegal_o) begin
            misaligned_o = 1'b0;
        end

        we_o    = 4'b0000;
        wdata_o = wdata_i;
        if (write_i && !illegal_o) begin
            case (funct3_i)
                F3_SB: begin
                    we_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_SH: begin
                    we_o    = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                F3_SW: begin
                    we_o    = 4'b1111;
                    wdata_o = wdata_i;
                end
                default: begin
                    we_o    = 4'b0000;
                    wdata_o = wdata_i;
                end
            endcase
        end

        case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   rdata_o = rdata_i;
            F3_LBU:  rdata_o = {24'd0, byte_sel};
            F3_LHU:  rdata_o = {16'd0, half_sel};
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage between the core and data memory.
// One request at a time; IDLE -> ACCESS (mem_req/mem_ack handshake) -> RESP,
// or IDLE -> RESP directly for illegal/misaligned requests.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_write/req_funct3/req_addr/req_wdata  - core request
//   busy, resp_valid/resp_rdata/resp_misaligned/resp_illegal/resp_fault
//   mem_req/mem_addr/mem_we/mem_wdata, mem_rdata/mem_ack - data memory
// Optional macro LSU_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES without ack.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DMEM_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic                  resp_fault,
    output logic                  mem_req,
    output logic [DMEM_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    lsu_state_e            state_q, state_d;
    logic [DMEM_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  write_q, write_d;
    logic [3:0]            we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  ill_q, ill_d;
    logic                  fault_q, fault_d;
    logic                  timeout_hit;

    // The aligner sees the live request while idle (to classify it) and the
    // captured request afterwards (to extract load data on mem_ack).
    logic        idle;
    logic [2:0]  la_funct3;
    logic        la_write;
    logic [1:0]  la_addr_lo;
    logic [3:0]  la_we;
    logic [31:0] la_wdata, la_rdata;
    logic        la_mis, la_ill;

    assign idle       = (state_q == ST_IDLE);
    assign la_funct3  = idle ? req_funct3     : funct3_q;
    assign la_write   = idle ? req_write      : write_q;
    assign la_addr_lo = idle ? req_addr[1:0]  : addr_lo_q;

    lsu_lane_align u_align (
        .funct3_i     (la_funct3),
        .write_i      (la_write),
        .addr_lo_i    (la_addr_lo),
        .wdata_i      (req_wdata),
        .rdata_i      (mem_rdata),
        .we_o         (la_we),
        .wdata_o      (la_wdata),
        .rdata_o      (la_rdata),
        .misaligned_o (la_mis),
        .illegal_o    (la_ill)
    );

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:DMEM_WIDTH];

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero while idle, so it is always clear on entry to ACCESS.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == ST_ACCESS) && !mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires in the cycle whose un-acked increment reaches the limit.
    assign timeout_hit = (state_q == ST_ACCESS) && !mem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        addr_lo_d  = addr_lo_q;
        funct3_d   = funct3_q;
        write_d    = write_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mis_d      = mis_q;
        ill_d      = ill_q;
        fault_d    = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mem_addr_d = {req_addr[DMEM_WIDTH-1:2], 2'b00};
                    addr_lo_d  = req_addr[1:0];
                    funct3_d   = req_funct3;
                    write_d    = req_write;
                    we_d       = (la_ill || la_mis) ? 4'b0000 : la_we;
                    wdata_d    = req_write ? la_wdata : 32'd0;
                    rdata_d    = 32'd0;
                    mis_d      = la_mis;
                    ill_d      = la_ill;
                    fault_d    = 1'b0;
                    state_d    = (la_ill || la_mis) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    rdata_d = write_q ? 32'd0 : la_rdata;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            addr_lo_q  <= '0;
            funct3_q   <= '0;
            write_q    <= 1'b0;
            we_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            addr_lo_q  <= addr_lo_d;
            funct3_q   <= funct3_d;
            write_q    <= write_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
            fault_q    <= fault_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign resp_rdata      = resp_valid ? rdata_q : 32'd0;
    assign resp_misaligned = resp_valid && mis_q;
    assign resp_illegal    = resp_valid && ill_q;
`ifdef LSU_TIMEOUT_EN
    assign resp_fault      = resp_valid && fault_q;
`else
    assign resp_fault      = 1'b0;
`endif
    assign mem_req         = (state_q == ST_ACCESS);
    assign mem_addr        = mem_addr_q;
    assign mem_we          = mem_req ? we_q : 4'b0000;
    assign mem_wdata       = wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage sitting directly downstream of the rv32i core's load/store path, between the core and the data memory.
- Accepts one load/store request at a time.
- Checks alignment, generates byte-lane write enables and replicated store data.
- Runs a request/acknowledge handshake with a variable-latency memory.
- Returns sign/zero-extended load data to the core with a one-cycle response pulse.

Parameters:
DMEM_WIDTH, 16, byte-address width presented to data memory
TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ack (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core issues request this cycle (sampled only when busy=0)
req_write  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data, rs2 value
busy  out  1  state != IDLE
resp_valid  out  1  one-cycle pulse, response fields valid
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_misaligned  out  1  address not naturally aligned
resp_illegal  out  1  unsupported funct3
resp_fault  out  1  memory timeout (tied 0 without LSU_TIMEOUT_EN)
mem_req  out  1  memory request, held until mem_ack
mem_addr  out  DMEM_WIDTH  word-aligned byte address {req_addr[DMEM_WIDTH-1:2],2'b00}
mem_we  out  4  byte-lane write enables; 0000 for loads
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  memory completes access

Behaviour:
- FSM states:
  - IDLE, ACCESS, RESP.
  - Reset state is IDLE.
  - All outputs reset to 0.
- IDLE:
  - On req_valid, register addr/funct3/write/wdata.
  - Illegal funct3 (loads 011/110/111, stores 011..111), or misaligned access: go to RESP with the matching flag. No memory access. Illegal takes priority over misaligned.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=00.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req=1; mem_addr/mem_we/mem_wdata are driven from registers and stay stable.
  - On mem_ack, capture mem_rdata into the result register and go to RESP.
  - mem_ack outside ACCESS is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - Request accepted at cycle 0; mem_req rises at cycle 1.
  - mem_ack at cycle k gives resp_valid at k+1; minimum is resp_valid at cycle 2.
  - Error responses assert resp_valid at cycle 1.
- Store lanes:
  - SB: we=0001<<addr[1:0], wdata={4{b}}.
  - SH: we=0011<<addr[1:0], wdata={2{h}}.
  - SW: we=1111.
- Load extract:
  - Byte = rdata[8*addr[1:0]+:8]; halfword = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- busy=1 whenever state != IDLE. req_valid while busy is ignored, including during the RESP cycle. The core re-issues after busy falls.
- An asynchronous reset mid-ACCESS returns to IDLE immediately:
  - mem_req drops.
  - No resp_valid is produced.
  - A later stray mem_ack is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops and the FSM goes to RESP with resp_fault=1, resp_rdata=0.
  - mem_ack on the same cycle as the limit wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; resp_fault is constant 0.

Decomposition:
- funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encodings belong in the shared defines file used by control_unit.
- One natural combinational sub-module: lsu_lane_align. It takes funct3 and addr[1:0] and produces:
  - store path: we and replicated wdata;
  - load path: extract and extend from rdata;
  - the misaligned and illegal flags.

Test Plan:
- LW addr=0x00000104, mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x0104, mem_we=0000, resp_valid at cycle 5, resp_rdata=0xDEADBEEF.
- LB addr=0x103, mem_rdata=0x80FF0000, ack same cycle as mem_req -> resp_rdata=0xFFFFFF80; repeated as LBU -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
- SH addr=0x102, wdata=0x1234ABCD -> mem_we=1100, mem_wdata=0xABCDABCD; SB addr=0x101, wdata=0x55 -> mem_we=0010, mem_wdata=0x55555555.
- LW addr=0x102 -> mem_req never asserts, resp_valid at cycle 1 with resp_misaligned=1, resp_rdata=0. Load funct3=011 -> resp_illegal=1.
- Assert reset low 2 cycles into ACCESS, then release and deliver a stray mem_ack -> mem_req drops asynchronously, no resp_valid, FSM stays IDLE. A new LW completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack -> mem_req high 4 cycles, then resp_valid with resp_fault=1.
- Without LSU_TIMEOUT_EN, never ack -> busy stays 1 for 1000 cycles.
